// File: rtl/vga_pixel_capture_pkg.sv
// Shared definitions for the VGA pixel capture block.
//   cap_state_e   : capture FSM state encoding (also reported in the status register)
//   ADDR_*        : Avalon word addresses of the register map
//   ARM_BIT/ABORT_BIT : command bit positions in a write to ADDR_DATA
//   pack_pixel    : 24-bit {R,G,B} FIFO word -> 32-bit reader word
package vga_pixel_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_e;

   localparam logic [7:0] ADDR_DATA   = 8'd0;
   localparam logic [7:0] ADDR_STATUS = 8'd1;
   localparam logic [7:0] ADDR_LIMIT  = 8'd2;

   localparam int ARM_BIT   = 0;
   localparam int ABORT_BIT = 1;

   localparam int PIX_W = 24;

   function automatic logic [31:0] pack_pixel(input logic [PIX_W-1:0] pix);
      return {pix, 8'h00};
   endfunction

endpackage

// File: rtl/vga_pixel_capture_fifo.sv
// pix_fifo: synchronous show-ahead FIFO holding captured pixels.
//   clk, reset_n : clock, async active-low reset
//   push_i/din_i : write request and data; a push while full is dropped unless a pop
//                  happens in the same cycle (the pop frees the slot)
//   pop_i        : read request; ignored while empty
//   flush_i      : empties the FIFO, wins over push/pop
//   dout_o       : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy
module pix_fifo #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 24,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok, push_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/vga_pixel_capture.sv
// vga_pixel_capture: captures the visible pixels of one armed VGA frame into a FIFO
// that software drains over Avalon-MM.
//   clk, reset_n            : clock, async active-low reset
//   chipselect/read/write/address/writedata/readdata : Avalon slave, zero wait states,
//                             readdata combinational; reading ADDR_DATA pops the FIFO
//   pix_en, VGA_R/G/B, HSYNC, VSYNC, VGA_BLANK_n : pixel stream from the timing generator
//   busy                    : high in ARMED or CAPTURE
//   irq                     : high in DONE
// Optional build macro PIXCAP_DECIMATE_EN: keep only every other visible pixel of each
// line (column toggle cleared on HSYNC falling edge).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing in progress, FIFO contents retained
// ARMED   | FIFO flushed, waiting for VSYNC falling edge
// CAPTURE | pushing visible pixels until limit reached or next frame start
// DONE    | capture complete, irq raised, FIFO awaiting drain
module vga_pixel_capture
   import vga_pixel_capture_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [7:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        pix_en,
   input  logic [7:0]  VGA_R,
   input  logic [7:0]  VGA_G,
   input  logic [7:0]  VGA_B,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic        VGA_BLANK_n,
   output logic        busy,
   output logic        irq
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   cap_state_e       state_q, state_d;
   logic [CNT_W-1:0] seen_q, seen_d, seen_inc;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             irq_q, irq_d;
   logic             vsync_q;

   logic             frame_start;
   logic             wr_acc, rd_acc;
   logic             cmd_wr, arm, abort;
   logic             qual, take, accept;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [PIX_W-1:0] fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic             unused_ok;

   assign frame_start = vsync_q & ~VSYNC;

   assign wr_acc = chipselect & write;
   assign rd_acc = chipselect & read;
   assign cmd_wr = wr_acc & (address == ADDR_DATA);
   assign abort  = cmd_wr & writedata[ABORT_BIT];
   assign arm    = cmd_wr & writedata[ARM_BIT] & ~writedata[ABORT_BIT];

   assign qual = pix_en & VGA_BLANK_n;

`ifdef PIXCAP_DECIMATE_EN
   logic hsync_q;
   logic toggle_q, toggle_d;

   assign take     = qual & ~toggle_q;
   assign toggle_d = (hsync_q & ~HSYNC) ? 1'b0 : (toggle_q ^ qual);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q  <= 1'b1;
         toggle_q <= 1'b0;
      end else begin
         hsync_q  <= HSYNC;
         toggle_q <= toggle_d;
      end
   end
`else
   assign take = qual;
`endif

   // A command write in the same cycle as a pixel wins: arm flushes, abort stops.
   assign accept   = (state_q == CAPTURE) & take & ~arm & ~abort;
   assign fifo_pop = rd_acc & (address == ADDR_DATA);
   assign seen_inc = seen_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      limit_d = limit_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE:    if (arm) state_d = ARMED;
         ARMED:   if (frame_start) state_d = CAPTURE;
         CAPTURE: begin
            if (accept) begin
               seen_d = seen_inc;
               if (seen_inc == limit_q) state_d = DONE;
            end
            if (frame_start) state_d = DONE;
         end
         DONE:    if (arm) state_d = ARMED;
         default: state_d = IDLE;
      endcase

      // Dropped only if the FIFO is full and no pop frees a slot this cycle.
      if (accept && fifo_full && !(fifo_pop && !fifo_empty)) ovf_d = 1'b1;

      if (arm) begin
         state_d = ARMED;
         seen_d  = '0;
         ovf_d   = 1'b0;
      end
      if (abort) state_d = IDLE;

      if (wr_acc && (address == ADDR_LIMIT) && (state_q == IDLE || state_q == DONE)) begin
         limit_d = (writedata[CNT_W-1:0] == '0) ? DEPTH_CNT : writedata[CNT_W-1:0];
      end

      busy_d = (state_d == ARMED) || (state_d == CAPTURE);
      irq_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         seen_q  <= '0;
         limit_q <= DEPTH_CNT;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         irq_q   <= 1'b0;
         vsync_q <= 1'b1;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
         limit_q <= limit_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         irq_q   <= irq_d;
         vsync_q <= VSYNC;
      end
   end

   assign busy = busy_q;
   assign irq  = irq_q;

   pix_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PIX_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (accept),
      .din_i   ({VGA_R, VGA_G, VGA_B}),
      .pop_i   (fifo_pop),
      .flush_i (arm),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      readdata = '0;
      if (rd_acc) begin
         unique case (address)
            ADDR_DATA:   readdata = fifo_empty ? 32'h0 : pack_pixel(fifo_dout);
            ADDR_STATUS: begin
               readdata[31:30]      = state_q;
               readdata[29]         = ovf_q;
               readdata[CNT_W-1:0]  = fifo_count;
            end
            ADDR_LIMIT:  readdata[CNT_W-1:0] = limit_q;
            default:     readdata = '0;
         endcase
      end
   end

   // Upper command/limit bits carry no meaning; HSYNC only matters with decimation.
   assign unused_ok = ^{writedata[31:CNT_W], HSYNC};

endmodule
